parity_stream_checker: RTL and testbench

- Streaming, parametrised parity unit; the successor to the team's combinational 4-bit odd-ones LED detector.
- Accepts WIDTH-bit words over a valid/ready handshake and computes per-word parity (even/odd mode).
- Checks each word against a supplied parity bit and accumulates parity and error status across multi-word frames.
- Drives a registered result stream, a saturating error counter and a sticky error LED; sits between a board-level data source and display/status logic.

---
 rtl/parity_pkg.sv | 25 ++
 rtl/parity_stream_checker_if.sv | 38 +++
 rtl/parity_reduce.sv | 24 ++
 rtl/parity_stream_checker.sv | 150 +++++++++++++++
 tb/tb_parity_stream_checker.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// Shared constants, FSM encodings and the parity helper for the parity stream checker.
package parity_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_WORDS = 16;
  localparam int DEF_CNT_W     = 8;

  // Widest word the parity helper handles; narrower words are zero-extended.
  localparam int PAR_MAX_W = 64;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_IN_FRAME = 1'b1;

  // Odd mode: 1 when the count of ones is odd. Even mode: the inverse.
  function automatic logic par_of(input logic [PAR_MAX_W-1:0] data, input logic odd);
    logic raw;
    raw = ^data;
    if (odd) begin
      par_of = raw;
    end else begin
      par_of = ~raw;
    end
  endfunction

endpackage

// File: rtl/parity_stream_checker_if.sv
// Word-in / result-out handshake bundle of the parity stream checker.
interface parity_stream_checker_if
  import parity_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             mode_odd;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_word_par;
  logic             out_word_err;
  logic             out_last;
  logic             out_frame_par;
  logic             out_frame_err;
  logic             out_ovf;
  logic [CNT_W-1:0] err_count;
  logic             led;

  modport master (
    output mode_odd, in_valid, in_data, in_par, in_last, out_ready,
    input  in_ready, out_valid, out_word_par, out_word_err, out_last,
           out_frame_par, out_frame_err, out_ovf, err_count, led
  );

  modport slave (
    input  mode_odd, in_valid, in_data, in_par, in_last, out_ready,
    output in_ready, out_valid, out_word_par, out_word_err, out_last,
           out_frame_par, out_frame_err, out_ovf, err_count, led
  );

endinterface

// File: rtl/parity_reduce.sv
// Combinational XOR tree over one word: raw XOR plus the mode-adjusted parity.
module parity_reduce
  import parity_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             odd,
  output logic             raw,
  output logic             par
);

  logic [PAR_MAX_W-1:0] ext_s;

  // Zero-extend the word so the shared helper can be used at any width.
  always_comb begin
    ext_s              = {PAR_MAX_W{1'b0}};
    ext_s[WIDTH-1:0]   = data;
  end

  assign raw = ^data;
  assign par = par_of(ext_s, odd);

endmodule

// File: rtl/parity_stream_checker.sv
// Streaming parity checker: per-word parity/error, frame accumulation, error counter and sticky LED.
module parity_stream_checker
  import parity_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic                    clk,
  input logic                    rst_n,
  parity_stream_checker_if.slave bus
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  logic [0:0]       state_r;
  logic [CW-1:0]    word_cnt_r;
  logic             acc_raw_r;
  logic             acc_err_r;
  logic             mode_r;

  logic             out_valid_r;
  logic             out_word_par_r;
  logic             out_word_err_r;
  logic             out_last_r;
  logic             out_frame_par_r;
  logic             out_frame_err_r;
  logic             out_ovf_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic             led_r;

  logic             accept_s;
  logic             eff_odd_s;
  logic             word_raw_s;
  logic             word_par_s;
  logic             word_err_s;
  logic [CW-1:0]    cnt_next_s;
  logic             force_close_s;
  logic             closing_s;
  logic             frame_raw_s;
  logic             frame_par_s;
  logic             frame_err_s;

  assign bus.in_ready = !out_valid_r || bus.out_ready;
  assign accept_s     = bus.in_valid && bus.in_ready;

  parity_reduce #(.WIDTH(WIDTH)) u_word_reduce (
    .data (bus.in_data),
    .odd  (eff_odd_s),
    .raw  (word_raw_s),
    .par  (word_par_s)
  );

  // Effective mode: a frame's first word uses the live input, later words the latched copy.
  always_comb begin
    case (state_r)
      ST_IDLE:     eff_odd_s = bus.mode_odd;
      ST_IN_FRAME: eff_odd_s = mode_r;
      default:     eff_odd_s = bus.mode_odd;
    endcase
  end

  // Next-result computation; the frame mode is applied once to the accumulated raw XOR.
  always_comb begin
    word_err_s  = word_par_s ^ bus.in_par;
    cnt_next_s  = word_cnt_r + CW'(1);
    frame_raw_s = acc_raw_r ^ word_raw_s;
    frame_par_s = par_of({{(PAR_MAX_W-1){1'b0}}, frame_raw_s}, eff_odd_s);
    if ((state_r == ST_IN_FRAME) && !bus.in_last && (cnt_next_s == CW'(MAX_WORDS))) begin
      force_close_s = 1'b1;
    end else begin
      force_close_s = 1'b0;
    end
    closing_s   = bus.in_last || force_close_s;
    frame_err_s = acc_err_r || word_err_s || force_close_s;
  end

  // Frame state machine, word counter, accumulators and latched mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      word_cnt_r <= {CW{1'b0}};
      acc_raw_r  <= 1'b0;
      acc_err_r  <= 1'b0;
      mode_r     <= 1'b0;
    end else if (accept_s) begin
      if (closing_s) begin
        state_r    <= ST_IDLE;
        word_cnt_r <= {CW{1'b0}};
        acc_raw_r  <= 1'b0;
        acc_err_r  <= 1'b0;
      end else begin
        state_r    <= ST_IN_FRAME;
        word_cnt_r <= cnt_next_s;
        acc_raw_r  <= frame_raw_s;
        acc_err_r  <= acc_err_r || word_err_s;
      end
      mode_r <= eff_odd_s;
    end
  end

  // Single output register: loads on accept, drops valid on a consume without a new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r     <= 1'b0;
      out_word_par_r  <= 1'b0;
      out_word_err_r  <= 1'b0;
      out_last_r      <= 1'b0;
      out_frame_par_r <= 1'b0;
      out_frame_err_r <= 1'b0;
      out_ovf_r       <= 1'b0;
    end else if (accept_s) begin
      out_valid_r     <= 1'b1;
      out_word_par_r  <= word_par_s;
      out_word_err_r  <= word_err_s;
      out_last_r      <= closing_s;
      out_frame_par_r <= closing_s && frame_par_s;
      out_frame_err_r <= closing_s && frame_err_s;
      out_ovf_r       <= force_close_s;
    end else if (bus.out_ready) begin
      out_valid_r     <= 1'b0;
    end
  end

  // Saturating word-error counter and sticky frame-error LED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= {CNT_W{1'b0}};
      led_r     <= 1'b0;
    end else if (accept_s) begin
      if (word_err_s && (err_cnt_r != {CNT_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
      if (closing_s && frame_err_s) begin
        led_r <= 1'b1;
      end
    end
  end

  assign bus.out_valid     = out_valid_r;
  assign bus.out_word_par  = out_word_par_r;
  assign bus.out_word_err  = out_word_err_r;
  assign bus.out_last      = out_last_r;
  assign bus.out_frame_par = out_frame_par_r;
  assign bus.out_frame_err = out_frame_err_r;
  assign bus.out_ovf       = out_ovf_r;
  assign bus.err_count     = err_cnt_r;
  assign bus.led           = led_r;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed bench: two checker instances share stimulus; the second has a 2-bit error counter.
module tb_parity_stream_checker;

  logic       clk;
  logic       rst_n;
  logic       mode_odd;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_par;
  logic       in_last;
  logic       out_ready;

  int n_tests;
  int n_fail;

  parity_stream_checker_if #(.WIDTH(4), .CNT_W(8)) bus_a ();
  parity_stream_checker_if #(.WIDTH(4), .CNT_W(2)) bus_b ();

  assign bus_a.mode_odd  = mode_odd;
  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_par    = in_par;
  assign bus_a.in_last   = in_last;
  assign bus_a.out_ready = out_ready;
  assign bus_b.mode_odd  = mode_odd;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_par    = in_par;
  assign bus_b.in_last   = in_last;
  assign bus_b.out_ready = out_ready;

  parity_stream_checker #(.WIDTH(4), .MAX_WORDS(4), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  parity_stream_checker #(.WIDTH(4), .MAX_WORDS(16), .CNT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic p, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
  endtask

  initial begin
    logic [15:0] odd_tbl;
    odd_tbl   = 16'h6996;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    mode_odd  = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'b0000;
    in_par    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_word_par",  32'(bus_a.out_word_par), 32'd0);
    chk("rst_last",      32'(bus_a.out_last), 32'd0);
    chk("rst_err_count", 32'(bus_a.err_count), 32'd0);
    chk("rst_led",       32'(bus_a.led), 32'd0);
    chk("rst_in_ready",  32'(bus_a.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-word odd frame 0111 with matching parity.
    mode_odd = 1'b1;
    send(4'b0111, 1'b1, 1'b1);
    chk("t1_valid",     32'(bus_a.out_valid), 32'd1);
    chk("t1_word_par",  32'(bus_a.out_word_par), 32'd1);
    chk("t1_word_err",  32'(bus_a.out_word_err), 32'd0);
    chk("t1_last",      32'(bus_a.out_last), 32'd1);
    chk("t1_frame_par", 32'(bus_a.out_frame_par), 32'd1);
    chk("t1_frame_err", 32'(bus_a.out_frame_err), 32'd0);
    chk("t1_led",       32'(bus_a.led), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_drain", 32'(bus_a.out_valid), 32'd0);

    // Exhaustive 4-bit sweep, odd mode, in_par=0, one word per frame.
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b0, 1'b1);
      chk($sformatf("sweep_par_%0d", i), 32'(bus_a.out_word_par), 32'(odd_tbl[i]));
      chk($sformatf("sweep_err_%0d", i), 32'(bus_a.out_word_err), 32'(odd_tbl[i]));
    end
    chk("sweep_err_count", 32'(bus_a.err_count), 32'd8);
    chk("sweep_sat_count", 32'(bus_b.err_count), 32'd3);
    chk("sweep_led",       32'(bus_a.led), 32'd1);

    // Three-word even-mode frame with correct parity bits.
    do_reset();
    mode_odd = 1'b0;
    send(4'b0001, 1'b0, 1'b0);
    chk("f1_w1_par",  32'(bus_a.out_word_par), 32'd0);
    chk("f1_w1_last", 32'(bus_a.out_last), 32'd0);
    send(4'b0011, 1'b1, 1'b0);
    chk("f1_w2_par",  32'(bus_a.out_word_par), 32'd1);
    chk("f1_w2_err",  32'(bus_a.out_word_err), 32'd0);
    send(4'b1000, 1'b0, 1'b1);
    chk("f1_last",      32'(bus_a.out_last), 32'd1);
    chk("f1_frame_err", 32'(bus_a.out_frame_err), 32'd0);
    chk("f1_led",       32'(bus_a.led), 32'd0);

    // Same frame with word 2 parity flipped; mode_odd toggles mid-frame and must be ignored.
    send(4'b0001, 1'b0, 1'b0);
    mode_odd = 1'b1;
    send(4'b0011, 1'b0, 1'b0);
    chk("f2_w2_err", 32'(bus_a.out_word_err), 32'd1);
    send(4'b1000, 1'b0, 1'b1);
    chk("f2_w3_err",     32'(bus_a.out_word_err), 32'd0);
    chk("f2_last",       32'(bus_a.out_last), 32'd1);
    chk("f2_frame_err",  32'(bus_a.out_frame_err), 32'd1);
    chk("f2_led",        32'(bus_a.led), 32'd1);
    chk("f2_err_count",  32'(bus_a.err_count), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("f2_led_sticky", 32'(bus_a.led), 32'd1);

    // Backpressure: first word accepted, then five stalled cycles, then release.
    mode_odd  = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'b0001;
    in_par    = 1'b1;
    in_last   = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_first_valid", 32'(bus_a.out_valid), 32'd1);
    in_data = 4'b0011;
    in_par  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_ready_%0d", k), 32'(bus_a.in_ready), 32'd0);
      chk($sformatf("bp_hold_%0d", k),  32'(bus_a.out_word_par), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_b_valid", 32'(bus_a.out_valid), 32'd1);
    chk("bp_b_par",   32'(bus_a.out_word_par), 32'd0);
    in_data = 4'b0111;
    in_par  = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_c_par", 32'(bus_a.out_word_par), 32'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_drain",     32'(bus_a.out_valid), 32'd0);
    chk("bp_err_count", 32'(bus_a.err_count), 32'd1);

    // Forced close at MAX_WORDS=4, then a new frame, then reset mid-frame.
    do_reset();
    mode_odd = 1'b1;
    send(4'b0001, 1'b1, 1'b0);
    send(4'b0011, 1'b0, 1'b0);
    send(4'b0001, 1'b1, 1'b0);
    chk("ovf_w3_last", 32'(bus_a.out_last), 32'd0);
    send(4'b0111, 1'b1, 1'b0);
    chk("ovf_last",      32'(bus_a.out_last), 32'd1);
    chk("ovf_flag",      32'(bus_a.out_ovf), 32'd1);
    chk("ovf_frame_err", 32'(bus_a.out_frame_err), 32'd1);
    chk("ovf_frame_par", 32'(bus_a.out_frame_par), 32'd1);
    chk("ovf_word_err",  32'(bus_a.out_word_err), 32'd0);
    send(4'b0011, 1'b0, 1'b0);
    chk("ovf_w5_last", 32'(bus_a.out_last), 32'd0);
    chk("ovf_w5_flag", 32'(bus_a.out_ovf), 32'd0);
    send(4'b0111, 1'b1, 1'b0);
    chk("ovf_w6_last", 32'(bus_a.out_last), 32'd0);
    chk("ovf_w6_par",  32'(bus_a.out_word_par), 32'd1);
    chk("ovf_led",     32'(bus_a.led), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("mid_rst_par",   32'(bus_a.out_word_par), 32'd0);
    chk("mid_rst_led",   32'(bus_a.led), 32'd0);
    chk("mid_rst_cnt",   32'(bus_b.err_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'b0010, 1'b1, 1'b1);
    chk("post_rst_last",      32'(bus_a.out_last), 32'd1);
    chk("post_rst_ovf",       32'(bus_a.out_ovf), 32'd0);
    chk("post_rst_frame_par", 32'(bus_a.out_frame_par), 32'd1);
    chk("post_rst_frame_err", 32'(bus_a.out_frame_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
